// File: rtl/sram_pkg.sv
// Shared types and access-decoding helpers for the OTTER dual-port Wishbone block RAM.
package sram_pkg;

    typedef enum logic [1:0] {
        SizeByte   = 2'b00,
        SizeHalf   = 2'b01,
        SizeWord   = 2'b10,
        SizeDouble = 2'b11
    } size_e;

    typedef enum logic {
        SignSigned   = 1'b0,
        SignUnsigned = 1'b1
    } sign_e;

    // Byte-enable mask for an access of the given size starting at lane `offset`.
    function automatic logic [7:0] lane_mask(input size_e size, input logic [2:0] offset,
                                             input int unsigned lanes);
        logic [7:0] base;
        logic [7:0] mask;
        unique case (size)
            SizeByte:   base = 8'h01;
            SizeHalf:   base = 8'h03;
            SizeWord:   base = 8'h0F;
            SizeDouble: base = 8'hFF;
        endcase
        mask = base << offset;
        if (lanes < 8) begin
            mask = mask & 8'h0F;
        end
        return mask;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [2:0] offset,
                                        input int unsigned data_width);
        logic bad;
        unique case (size)
            SizeByte:   bad = 1'b0;
            SizeHalf:   bad = offset[0];
            SizeWord:   bad = |offset[1:0];
            SizeDouble: bad = (data_width != 64) || (|offset);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_ack_pipe.sv
// Response pipeline for one port: shifts {valid, err, data} through READ_LATENCY stages,
// dropping everything in flight when the master releases cyc.
module sram_ack_pipe #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ack,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dat
);

    localparam int unsigned Last = READ_LATENCY - 1;

    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] err_q;
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else if (!cyc) begin
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            data_q[0]  <= in_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign ack = valid_q[Last] & ~err_q[Last];
    assign err = valid_q[Last] & err_q[Last];
    // Data is forced to zero outside an ack so flushed or reset slots never leak stale words.
    assign dat = ack ? data_q[Last] : '0;

endmodule

// File: rtl/sram_wb.sv
// Dual-port Wishbone-pipelined block RAM: read-only instruction port I and a
// read/write data port D with size, sign and alignment handling.
module sram_wb
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 25,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cyc,
    input  logic                  i_stb,
    input  logic [31:0]           i_adr,
    output logic [DATA_WIDTH-1:0] i_dat,
    output logic                  i_ack,
    output logic                  i_err,
    output logic                  i_stall,
    input  logic                  d_cyc,
    input  logic                  d_stb,
    input  logic                  d_we,
    input  logic [31:0]           d_adr,
    input  logic [1:0]            d_size,
    input  logic                  d_sign,
    input  logic [DATA_WIDTH-1:0] d_wdat,
    output logic [DATA_WIDTH-1:0] d_rdat,
    output logic                  d_ack,
    output logic                  d_err,
    output logic                  d_stall
);

    localparam int unsigned LANES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS  = $clog2(LANES);
    localparam int unsigned WIDX_BITS = ADDR_WIDTH - OFF_BITS;
    localparam int unsigned DEPTH     = 2 ** WIDX_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [WIDX_BITS-1:0]  i_widx, d_widx;
    logic [OFF_BITS-1:0]   i_off, d_off;
    logic [2:0]            d_off3;
    size_e                 d_size_e;
    logic                  i_mis, d_mis;
    logic                  i_accept, d_accept, d_wr_ok;
    logic [7:0]            d_mask8;
    logic [LANES-1:0]      d_be;
    logic [DATA_WIDTH-1:0] d_wdat_sh;
    logic [DATA_WIDTH-1:0] i_word, d_word, d_shifted, d_ext;
    logic [DATA_WIDTH-1:0] i_in_data, d_in_data;
    logic [DATA_WIDTH-1:0] keep;
    logic                  msb;
    logic                  unused_bits;

    assign i_widx   = i_adr[ADDR_WIDTH-1:OFF_BITS];
    assign i_off    = i_adr[OFF_BITS-1:0];
    assign d_widx   = d_adr[ADDR_WIDTH-1:OFF_BITS];
    assign d_off    = d_adr[OFF_BITS-1:0];
    assign d_off3   = 3'(d_off);
    assign d_size_e = size_e'(d_size);

    assign i_mis = |i_off;
    assign d_mis = misaligned(d_size_e, d_off3, DATA_WIDTH);

    // Requests presented while rst is high must neither be accepted nor touch the array.
    assign d_accept = d_cyc & d_stb & ~rst;
    assign d_wr_ok  = d_accept & d_we & ~d_mis;
    assign d_stall  = 1'b0;
    assign i_stall  = d_wr_ok & i_cyc & i_stb & (i_widx == d_widx);
    assign i_accept = i_cyc & i_stb & ~i_stall & ~rst;

    assign d_mask8   = lane_mask(d_size_e, d_off3, LANES);
    assign d_be      = d_mask8[LANES-1:0];
    assign d_wdat_sh = d_wdat << {d_off3, 3'b000};

    always_ff @(posedge clk) begin
        if (d_wr_ok) begin
            for (int l = 0; l < LANES; l++) begin
                if (d_be[l]) begin
                    mem[d_widx][8*l +: 8] <= d_wdat_sh[8*l +: 8];
                end
            end
        end
    end

    assign i_word    = mem[i_widx];
    assign d_word    = mem[d_widx];
    assign d_shifted = d_word >> {d_off3, 3'b000};

    always_comb begin
        keep = '1;
        msb  = 1'b0;
        unique case (d_size_e)
            SizeByte: begin
                keep = DATA_WIDTH'(8'hFF);
                msb  = d_shifted[7];
            end
            SizeHalf: begin
                keep = DATA_WIDTH'(16'hFFFF);
                msb  = d_shifted[15];
            end
            SizeWord: begin
                keep = DATA_WIDTH'(32'hFFFF_FFFF);
                msb  = d_shifted[31];
            end
            SizeDouble: begin
                keep = '1;
                msb  = 1'b0;
            end
        endcase
        d_ext = d_shifted & keep;
        if (sign_e'(d_sign) == SignSigned && msb) begin
            d_ext = d_ext | ~keep;
        end
    end

    assign i_in_data = i_mis ? '0 : i_word;
    assign d_in_data = (d_we || d_mis) ? '0 : d_ext;

    sram_ack_pipe #(
        .READ_LATENCY(READ_LATENCY),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_i_pipe (
        .clk     (clk),
        .rst     (rst),
        .cyc     (i_cyc),
        .in_valid(i_accept),
        .in_err  (i_mis),
        .in_data (i_in_data),
        .ack     (i_ack),
        .err     (i_err),
        .dat     (i_dat)
    );

    sram_ack_pipe #(
        .READ_LATENCY(READ_LATENCY),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_d_pipe (
        .clk     (clk),
        .rst     (rst),
        .cyc     (d_cyc),
        .in_valid(d_accept),
        .in_err  (d_mis),
        .in_data (d_in_data),
        .ack     (d_ack),
        .err     (d_err),
        .dat     (d_rdat)
    );

    assign unused_bits = ^{i_adr[31:ADDR_WIDTH], d_adr[31:ADDR_WIDTH]};

endmodule

// File: tb/tb_sram_wb.sv
// Directed bench for sram_wb: 32-bit/L1, 32-bit/L2 and 64-bit/L1 builds side by side.
module tb_sram_wb;

    localparam int unsigned AW = 12;
    localparam logic [1:0] BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, DOUBLE = 2'b11;
    localparam logic SGN = 1'b0, UNS = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: 32-bit latency 1, B: 32-bit latency 2, C: 64-bit latency 1
    logic        a_i_cyc, a_i_stb, a_i_ack, a_i_err, a_i_stall;
    logic [31:0] a_i_adr, a_i_dat;
    logic        a_d_cyc, a_d_stb, a_d_we, a_d_sign, a_d_ack, a_d_err, a_d_stall;
    logic [31:0] a_d_adr, a_d_wdat, a_d_rdat;
    logic [1:0]  a_d_size;
    logic        b_i_cyc, b_i_stb, b_i_ack, b_i_err, b_i_stall;
    logic [31:0] b_i_adr, b_i_dat;
    logic        b_d_cyc, b_d_stb, b_d_we, b_d_sign, b_d_ack, b_d_err, b_d_stall;
    logic [31:0] b_d_adr, b_d_wdat, b_d_rdat;
    logic [1:0]  b_d_size;
    logic        c_i_cyc, c_i_stb, c_i_ack, c_i_err, c_i_stall;
    logic [31:0] c_i_adr;
    logic [63:0] c_i_dat;
    logic        c_d_cyc, c_d_stb, c_d_we, c_d_sign, c_d_ack, c_d_err, c_d_stall;
    logic [31:0] c_d_adr;
    logic [63:0] c_d_wdat, c_d_rdat;
    logic [1:0]  c_d_size;

    sram_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .i_cyc(a_i_cyc), .i_stb(a_i_stb), .i_adr(a_i_adr), .i_dat(a_i_dat),
        .i_ack(a_i_ack), .i_err(a_i_err), .i_stall(a_i_stall),
        .d_cyc(a_d_cyc), .d_stb(a_d_stb), .d_we(a_d_we), .d_adr(a_d_adr), .d_size(a_d_size),
        .d_sign(a_d_sign), .d_wdat(a_d_wdat), .d_rdat(a_d_rdat),
        .d_ack(a_d_ack), .d_err(a_d_err), .d_stall(a_d_stall)
    );

    sram_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(2)) u_b (
        .clk(clk), .rst(rst),
        .i_cyc(b_i_cyc), .i_stb(b_i_stb), .i_adr(b_i_adr), .i_dat(b_i_dat),
        .i_ack(b_i_ack), .i_err(b_i_err), .i_stall(b_i_stall),
        .d_cyc(b_d_cyc), .d_stb(b_d_stb), .d_we(b_d_we), .d_adr(b_d_adr), .d_size(b_d_size),
        .d_sign(b_d_sign), .d_wdat(b_d_wdat), .d_rdat(b_d_rdat),
        .d_ack(b_d_ack), .d_err(b_d_err), .d_stall(b_d_stall)
    );

    sram_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .READ_LATENCY(1)) u_c (
        .clk(clk), .rst(rst),
        .i_cyc(c_i_cyc), .i_stb(c_i_stb), .i_adr(c_i_adr), .i_dat(c_i_dat),
        .i_ack(c_i_ack), .i_err(c_i_err), .i_stall(c_i_stall),
        .d_cyc(c_d_cyc), .d_stb(c_d_stb), .d_we(c_d_we), .d_adr(c_d_adr), .d_size(c_d_size),
        .d_sign(c_d_sign), .d_wdat(c_d_wdat), .d_rdat(c_d_rdat),
        .d_ack(c_d_ack), .d_err(c_d_err), .d_stall(c_d_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_d(input int dut, input logic cyc, input logic stb, input logic we,
                           input logic [1:0] size, input logic sgn, input logic [31:0] adr,
                           input logic [63:0] wdat);
        case (dut)
            0: begin
                a_d_cyc = cyc; a_d_stb = stb; a_d_we = we; a_d_size = size;
                a_d_sign = sgn; a_d_adr = adr; a_d_wdat = wdat[31:0];
            end
            1: begin
                b_d_cyc = cyc; b_d_stb = stb; b_d_we = we; b_d_size = size;
                b_d_sign = sgn; b_d_adr = adr; b_d_wdat = wdat[31:0];
            end
            default: begin
                c_d_cyc = cyc; c_d_stb = stb; c_d_we = we; c_d_size = size;
                c_d_sign = sgn; c_d_adr = adr; c_d_wdat = wdat;
            end
        endcase
    endtask

    task automatic sample_d(input int dut, output logic [63:0] rdat, output logic ack,
                            output logic err);
        case (dut)
            0:       begin rdat = {32'h0, a_d_rdat}; ack = a_d_ack; err = a_d_err; end
            1:       begin rdat = {32'h0, b_d_rdat}; ack = b_d_ack; err = b_d_err; end
            default: begin rdat = c_d_rdat;          ack = c_d_ack; err = c_d_err; end
        endcase
    endtask

    // One port-D transfer; called just after a rising edge, returns just after one.
    task automatic d_xfer(input int dut, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] adr, input logic [63:0] wdat,
                          output logic [63:0] rdat, output logic ack, output logic err,
                          output logic ack_next);
        logic [63:0] r2;
        logic        e2;
        int          lat;
        lat = (dut == 1) ? 2 : 1;
        drive_d(dut, 1'b1, 1'b1, we, size, sgn, adr, wdat);
        @(posedge clk); #1;
        drive_d(dut, 1'b1, 1'b0, 1'b0, size, sgn, adr, 64'h0);
        repeat (lat - 1) begin @(posedge clk); #1; end
        sample_d(dut, rdat, ack, err);
        @(posedge clk); #1;
        sample_d(dut, r2, ack_next, e2);
        drive_d(dut, 1'b0, 1'b0, 1'b0, BYTE, SGN, 32'h0, 64'h0);
    endtask

    logic [63:0] rd;
    logic        ak, er, an, seen;
    logic [31:0] words [4];

    initial begin
        words = '{32'h0000_0113, 32'h0020_0093, 32'hDEAD_0004, 32'hCAFE_000C};
        rst = 1'b1;
        {a_i_cyc, a_i_stb, b_i_cyc, b_i_stb, c_i_cyc, c_i_stb} = '0;
        a_i_adr = '0; b_i_adr = '0; c_i_adr = '0;
        drive_d(0, 1'b0, 1'b0, 1'b0, BYTE, SGN, 32'h0, 64'h0);
        drive_d(1, 1'b0, 1'b0, 1'b0, BYTE, SGN, 32'h0, 64'h0);
        drive_d(2, 1'b0, 1'b0, 1'b0, BYTE, SGN, 32'h0, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_iack", a_i_ack, 0);
        check("rst_a_dack", a_d_ack, 0);
        check("rst_b_idat", b_i_dat, 0);
        check("rst_a_istall", a_i_stall, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 32-bit, latency 1: word write then signed/unsigned byte reads
        d_xfer(0, 1, WORD, SGN, 32'h10, 64'hDEADBEEF, rd, ak, er, an);
        check("wr_ack", ak, 1);
        check("wr_rdat", rd, 0);
        check("wr_ack_once", an, 0);
        d_xfer(0, 0, BYTE, SGN, 32'h13, 64'h0, rd, ak, er, an);
        check("rd_byte_s_ack", ak, 1);
        check("rd_byte_s", rd, 64'hFFFF_FFDE);
        d_xfer(0, 0, BYTE, UNS, 32'h13, 64'h0, rd, ak, er, an);
        check("rd_byte_u", rd, 64'h0000_00DE);

        // Half write merges into an existing word; misaligned half errors and writes nothing
        d_xfer(0, 1, WORD, SGN, 32'h20, 64'hAABBCCDD, rd, ak, er, an);
        d_xfer(0, 1, HALF, SGN, 32'h22, 64'hEEEE1234, rd, ak, er, an);
        d_xfer(0, 0, WORD, SGN, 32'h20, 64'h0, rd, ak, er, an);
        check("half_merge", rd, 64'h1234_CCDD);
        d_xfer(0, 1, HALF, SGN, 32'h21, 64'h0000BEEF, rd, ak, er, an);
        check("half_mis_err", er, 1);
        check("half_mis_noack", ak, 0);
        d_xfer(0, 0, WORD, SGN, 32'h20, 64'h0, rd, ak, er, an);
        check("half_mis_nowr", rd, 64'h1234_CCDD);
        d_xfer(0, 0, HALF, SGN, 32'h20, 64'h0, rd, ak, er, an);
        check("rd_half_s", rd, 64'hFFFF_CCDD);
        d_xfer(0, 0, DOUBLE, SGN, 32'h20, 64'h0, rd, ak, er, an);
        check("dbl_on_32_err", er, 1);
        check("dbl_on_32_dat", rd, 0);

        // Collision: port D byte write and port I read of the same word in one cycle
        d_xfer(0, 1, WORD, SGN, 32'h40, 64'h11223344, rd, ak, er, an);
        drive_d(0, 1'b1, 1'b1, 1'b1, BYTE, SGN, 32'h40, 64'h55);
        a_i_cyc = 1'b1; a_i_stb = 1'b1; a_i_adr = 32'h40;
        #1;
        check("coll_stall", a_i_stall, 1);
        @(posedge clk); #1;
        drive_d(0, 1'b0, 1'b0, 1'b0, BYTE, SGN, 32'h0, 64'h0);
        check("coll_no_ack", a_i_ack, 0);
        #1;
        check("coll_stall_once", a_i_stall, 0);
        @(posedge clk); #1;
        a_i_stb = 1'b0;
        check("coll_ack", a_i_ack, 1);
        check("coll_dat", a_i_dat, 32'h1122_3355);
        a_i_cyc = 1'b0;

        // Misaligned instruction fetch
        a_i_cyc = 1'b1; a_i_stb = 1'b1; a_i_adr = 32'h42;
        @(posedge clk); #1;
        a_i_stb = 1'b0;
        check("i_mis_err", a_i_err, 1);
        check("i_mis_ack", a_i_ack, 0);
        check("i_mis_dat", a_i_dat, 0);
        a_i_cyc = 1'b0;

        // Latency 2: preload then four back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            d_xfer(1, 1, WORD, SGN, 32'(i * 4), {32'h0, words[i]}, rd, ak, er, an);
            check("b_wr_ack", ak, 1);
        end
        b_i_cyc = 1'b1; b_i_stb = 1'b1; b_i_adr = 32'h0;
        for (int s = 1; s <= 6; s++) begin
            @(posedge clk); #1;
            if (s < 4) b_i_adr = 32'(s * 4);
            else b_i_stb = 1'b0;
            if (s >= 2 && s <= 5) begin
                check("b2b_ack", b_i_ack, 1);
                check("b2b_dat", b_i_dat, words[s-2]);
            end else begin
                check("b2b_idle", b_i_ack, 0);
            end
        end
        b_i_cyc = 1'b0;

        // Latency 2: d_cyc drops the cycle after acceptance
        drive_d(1, 1'b1, 1'b1, 1'b0, WORD, SGN, 32'h4, 64'h0);
        @(posedge clk); #1;
        drive_d(1, 1'b0, 1'b0, 1'b0, WORD, SGN, 32'h4, 64'h0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | b_d_ack | b_d_err;
        end
        check("flush_no_ack", seen, 0);

        // Reset with one ack showing and one request in flight; port A tries a write during it
        b_i_cyc = 1'b1; b_i_stb = 1'b1; b_i_adr = 32'h8;
        @(posedge clk); #1;
        b_i_adr = 32'hC;
        @(posedge clk); #1;
        b_i_stb = 1'b0;
        check("pre_rst_ack", b_i_ack, 1);
        check("pre_rst_dat", b_i_dat, 32'hDEAD_0004);
        rst = 1'b1;
        drive_d(0, 1'b1, 1'b1, 1'b1, WORD, SGN, 32'h10, 64'hFFFFFFFF);
        #1;
        check("rst_ack_now", b_i_ack, 0);
        check("rst_dat_now", b_i_dat, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_d(0, 1'b0, 1'b0, 1'b0, BYTE, SGN, 32'h0, 64'h0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | b_i_ack;
        end
        check("rst_lost_ack", seen, 0);
        b_i_cyc = 1'b0;
        d_xfer(0, 0, WORD, SGN, 32'h10, 64'h0, rd, ak, er, an);
        check("rst_no_write", rd, 64'hDEAD_BEEF);
        d_xfer(1, 0, WORD, UNS, 32'hC, 64'h0, rd, ak, er, an);
        check("rst_mem_kept", rd, 64'hCAFE_000C);

        // 64-bit build
        d_xfer(2, 1, DOUBLE, SGN, 32'h8, 64'h0123456789ABCDEF, rd, ak, er, an);
        check("c_dbl_wr_ack", ak, 1);
        d_xfer(2, 0, WORD, SGN, 32'hC, 64'h0, rd, ak, er, an);
        check("c_word_hi", rd, 64'h0000_0000_0123_4567);
        d_xfer(2, 0, WORD, SGN, 32'h8, 64'h0, rd, ak, er, an);
        check("c_word_lo_s", rd, 64'hFFFF_FFFF_89AB_CDEF);
        d_xfer(2, 0, BYTE, UNS, 32'hF, 64'h0, rd, ak, er, an);
        check("c_byte_u", rd, 64'h01);
        d_xfer(2, 0, DOUBLE, SGN, 32'h8, 64'h0, rd, ak, er, an);
        check("c_dbl_rd", rd, 64'h0123_4567_89AB_CDEF);
        d_xfer(2, 0, DOUBLE, SGN, 32'h4, 64'h0, rd, ak, er, an);
        check("c_dbl_mis_err", er, 1);
        check("c_dbl_mis_ack", ak, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
